// File: rtl/upsampling_fifo_reader.sv
// Read-side burst controller: arms the FIFO threshold, pops one burst per M_Ready,
// and streams the words through a 2-entry skid buffer with burst_end/last tags.
module upsampling_fifo_reader #(
  parameter int WIDTH     = 128,
  parameter int ADDR_BITS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [19:0]        cfg_total,
  input  logic [ADDR_BITS:0] cfg_burst,
  input  logic               fifo_M_Ready,
  output logic [ADDR_BITS:0] fifo_M_count,
  output logic               fifo_rd_en,
  input  logic [WIDTH-1:0]   fifo_dout,
  input  logic               fifo_empty,
  output logic [WIDTH-1:0]   m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_burst_end,
  output logic               m_last,
  output logic               busy,
  output logic               done
);

  localparam int CW = ADDR_BITS + 1;
  localparam logic [CW-1:0] MAX_BURST = CW'(1) << (ADDR_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_BURST, S_FLUSH, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [19:0]     remaining_q, remaining_d;
  logic [CW-1:0]   burst_cfg_q, burst_cfg_d;
  logic [CW-1:0]   blen_q, blen_d;
  logic [CW-1:0]   issued_q, issued_d;
  logic [CW-1:0]   mcount_q, mcount_d;
  logic [1:0]      settle_q, settle_d;
  logic            inflight_q, inflight_d;
  logic            tag_be_q, tag_be_d;
  logic            tag_last_q, tag_last_d;
  logic [WIDTH+1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]      occ_q, occ_d;

  logic [CW-1:0]   blen_calc;
  logic [WIDTH+1:0] wr_word;
  logic            pop_out;
  logic [2:0]      pend;

  function automatic logic [CW-1:0] clamp_burst(input logic [CW-1:0] b);
    if (b == '0) return CW'(1);
    if (b > MAX_BURST) return MAX_BURST;
    return b;
  endfunction

  assign m_valid      = (occ_q != 2'd0);
  assign m_data       = e0_q[WIDTH-1:0];
  assign m_last       = m_valid & e0_q[WIDTH];
  assign m_burst_end  = m_valid & e0_q[WIDTH+1];
  assign fifo_M_count = mcount_q;

  assign pop_out = m_valid & m_ready;
  // Words already committed to the buffer once this cycle's drain is accounted for
  assign pend    = 3'(occ_q) + 3'(inflight_q) - 3'(pop_out);
  assign wr_word = {tag_be_q, tag_last_q, fifo_dout};

  always_comb begin
    if (remaining_q < 20'(burst_cfg_q)) blen_calc = remaining_q[CW-1:0];
    else                                blen_calc = burst_cfg_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = (remaining_q == 20'd0) ? S_FLUSH : S_WAIT;
      // The ready flag lags M_count by a register, so it is only trusted once settled
      S_WAIT:  if (settle_q == 2'd0 && fifo_M_Ready) state_d = S_BURST;
      S_BURST: if (issued_q == blen_q) state_d = (remaining_q != 20'd0) ? S_LOAD : S_FLUSH;
      S_FLUSH: if (occ_q == 2'd0 && !inflight_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    fifo_rd_en = (state_q == S_BURST) && (issued_q < blen_q) && !fifo_empty && (pend < 3'd2);
  end

  always_comb begin
    remaining_d = remaining_q;
    burst_cfg_d = burst_cfg_q;
    blen_d      = blen_q;
    issued_d    = issued_q;
    mcount_d    = mcount_q;
    settle_d    = settle_q;
    case (state_q)
      S_IDLE: if (start) begin
        remaining_d = cfg_total;
        burst_cfg_d = clamp_burst(cfg_burst);
      end
      S_LOAD: begin
        blen_d   = blen_calc;
        mcount_d = blen_calc;
        settle_d = 2'd2;
        issued_d = '0;
      end
      S_WAIT: if (settle_q != 2'd0) settle_d = settle_q - 2'd1;
      default: ;
    endcase
    if (fifo_rd_en) begin
      remaining_d = remaining_q - 20'd1;
      issued_d    = issued_q + CW'(1);
    end
    inflight_d = fifo_rd_en;
    tag_be_d   = fifo_rd_en && (issued_q == blen_q - CW'(1));
    tag_last_d = fifo_rd_en && (remaining_q == 20'd1);
  end

  // Output buffer: head is e0, writes land one cycle after the pop
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    case (occ_q)
      2'd0: if (inflight_q) begin
        e0_d  = wr_word;
        occ_d = 2'd1;
      end
      2'd1: begin
        if (inflight_q && pop_out) e0_d = wr_word;
        else if (inflight_q) begin
          e1_d  = wr_word;
          occ_d = 2'd2;
        end else if (pop_out) occ_d = 2'd0;
      end
      2'd2: if (pop_out) begin
        e0_d = e1_q;
        if (inflight_q) e1_d = wr_word;
        else            occ_d = 2'd1;
      end
      default: occ_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining_q <= '0;
      burst_cfg_q <= '0;
      blen_q      <= '0;
      issued_q    <= '0;
      mcount_q    <= '0;
      settle_q    <= '0;
      inflight_q  <= 1'b0;
      tag_be_q    <= 1'b0;
      tag_last_q  <= 1'b0;
      e0_q        <= '0;
      e1_q        <= '0;
      occ_q       <= '0;
    end else begin
      remaining_q <= remaining_d;
      burst_cfg_q <= burst_cfg_d;
      blen_q      <= blen_d;
      issued_q    <= issued_d;
      mcount_q    <= mcount_d;
      settle_q    <= settle_d;
      inflight_q  <= inflight_d;
      tag_be_q    <= tag_be_d;
      tag_last_q  <= tag_last_d;
      e0_q        <= e0_d;
      e1_q        <= e1_d;
      occ_q       <= occ_d;
    end
  end

endmodule

// File: tb/tb_upsampling_fifo_reader.sv
// Bench for upsampling_fifo_reader: a behavioural FIFO feeds a table of frames,
// plus hand-written zero-frame and mid-burst reset sequences.
module tb_upsampling_fifo_reader;
  localparam int WIDTH     = 128;
  localparam int ADDR_BITS = 10;

  typedef struct {
    int total;
    int burst;
    int feed;     // 0 = preload whole frame, 1 = one word every 2 cycles
    int rdy;      // 0 = m_ready held high, 1 = random backpressure
    int gate;     // force fifo_empty for 3 cycles mid-burst
    int restart;  // extra start pulse while busy
    int blen;     // effective burst length after clamping
  } vec_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start;
  logic [19:0]        cfg_total;
  logic [ADDR_BITS:0] cfg_burst;
  logic               fifo_M_Ready;
  logic [ADDR_BITS:0] fifo_M_count;
  logic               fifo_rd_en;
  logic [WIDTH-1:0]   fifo_dout;
  logic               fifo_empty;
  logic [WIDTH-1:0]   m_data;
  logic               m_valid;
  logic               m_ready;
  logic               m_burst_end;
  logic               m_last;
  logic               busy;
  logic               done;

  always #5 clk = ~clk;

  upsampling_fifo_reader #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_total(cfg_total), .cfg_burst(cfg_burst),
    .fifo_M_Ready(fifo_M_Ready), .fifo_M_count(fifo_M_count), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_burst_end(m_burst_end), .m_last(m_last), .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc_n = 0;
  int wr_seq = 1;
  logic [127:0] fq[$];
  bit gate_empty = 1'b0;
  int cur_blen = 1;

  logic [127:0] got_d[$];
  bit got_be[$];
  bit got_last[$];
  int mc_q[$];
  int n_acc, pop_idx, n_valid, done_cnt, done_cyc, last_hs, first_pop;
  bit stall_prev, pbe, plast, mrdy_prev, rd_s, busy_s, mval_s;
  logic [127:0] pdata;
  int mc_s;

  function automatic logic [127:0] wval(input int k);
    return {4{32'(k)}};
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic clr_mon();
    got_d.delete(); got_be.delete(); got_last.delete(); mc_q.delete();
    n_acc = 0; pop_idx = 0; n_valid = 0; done_cnt = 0;
    done_cyc = -1; last_hs = -1; first_pop = -1;
    stall_prev = 1'b0; mrdy_prev = 1'b0;
  endtask

  // One clock: sample and check at the falling edge, then advance the FIFO model
  task automatic cyc();
    fifo_empty = (fq.size() == 0) || gate_empty;
    @(negedge clk);
    cyc_n++;
    rd_s = fifo_rd_en; mc_s = int'(fifo_M_count); busy_s = busy; mval_s = m_valid;
    if (gate_empty) chk("gated_rd_en", longint'(fifo_rd_en), 0);
    if (stall_prev) begin
      chk("stall_valid", longint'(m_valid), 1);
      chkw("stall_data", m_data, pdata);
      chk("stall_burst_end", longint'(m_burst_end), longint'(pbe));
      chk("stall_last", longint'(m_last), longint'(plast));
    end
    stall_prev = m_valid && !m_ready;
    pdata = m_data; pbe = m_burst_end; plast = m_last;
    if (m_valid) n_valid++;
    if (m_valid && m_ready) begin
      got_d.push_back(m_data); got_be.push_back(m_burst_end); got_last.push_back(m_last);
      n_acc++;
      if (m_last) last_hs = cyc_n;
    end
    if (fifo_rd_en) begin
      chk("pop_nonempty", longint'(fq.size() != 0), 1);
      if (pop_idx % cur_blen == 0) begin
        mc_q.push_back(int'(fifo_M_count));
        chk("burst_start_ready", longint'(mrdy_prev), 1);
      end
      if (pop_idx == 0) first_pop = cyc_n;
      pop_idx++;
      chk("outstanding", longint'((pop_idx - n_acc) <= 3), 1);
    end
    if (done) begin done_cnt++; done_cyc = cyc_n; end
    mrdy_prev = fifo_M_Ready;
    @(posedge clk);
    #1;
    if (rd_s && fq.size() != 0) fifo_dout = fq.pop_front();
    fifo_M_Ready = (fq.size() >= mc_s);
  endtask

  task automatic run_frame(input vec_t v);
    int s, base, pushed, nxt, rem, k;
    clr_mon();
    fq.delete();
    cur_blen = v.blen;
    base = wr_seq;
    pushed = 0;
    if (v.feed == 0)
      for (int i = 0; i < v.total; i++) begin fq.push_back(wval(wr_seq)); wr_seq++; pushed++; end
    cfg_total = 20'(v.total); cfg_burst = 11'(v.burst);
    start = 1'b1; m_ready = 1'b1; gate_empty = 1'b0;
    cyc();
    s = cyc_n;
    start = 1'b0;
    for (int n = 0; n < 4000 && done_cnt == 0; n++) begin
      nxt = cyc_n + 1;
      m_ready = (v.rdy == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      gate_empty = (v.gate != 0) && nxt >= s + 7 && nxt <= s + 9;
      if (v.restart != 0 && nxt == s + 6) begin
        start = 1'b1; cfg_total = 20'd3; cfg_burst = 11'd1;
      end else start = 1'b0;
      if (v.feed == 1 && pushed < v.total && nxt % 2 == 0) begin
        fq.push_back(wval(wr_seq)); wr_seq++; pushed++;
      end
      cyc();
      if (cyc_n == s + 1) chk("busy_after_start", longint'(busy_s), 1);
    end
    gate_empty = 1'b0; start = 1'b0; m_ready = 1'b1;
    chk("done_seen", done_cnt, 1);
    cyc();
    chk("busy_after_done", longint'(busy_s), 0);
    chk("done_after_last", done_cyc - last_hs, 2);
    if (v.feed == 0) chk("first_pop_latency", first_pop - s, 5);
    chk("pop_count", pop_idx, v.total);
    chk("word_count", got_d.size(), v.total);
    for (int i = 0; i < got_d.size() && i < v.total; i++) begin
      chkw("word_data", got_d[i], wval(base + i));
      chk("word_burst_end", longint'(got_be[i]), longint'(((i + 1) % v.blen == 0) || (i + 1 == v.total)));
      chk("word_last", longint'(got_last[i]), longint'(i + 1 == v.total));
    end
    rem = v.total; k = 0;
    while (rem > 0) begin
      int b;
      b = (v.blen < rem) ? v.blen : rem;
      chk("m_count_seq", (k < mc_q.size()) ? mc_q[k] : -1, b);
      rem -= b; k++;
    end
    chk("burst_count", mc_q.size(), k);
  endtask

  vec_t vecs[7];

  initial begin
    int s;
    vecs[0] = '{8, 16, 0, 0, 0, 0, 16};
    vecs[1] = '{40, 16, 1, 0, 0, 0, 16};
    vecs[2] = '{64, 64, 0, 1, 0, 0, 64};
    vecs[3] = '{12, 12, 0, 0, 1, 0, 12};
    vecs[4] = '{5, 0, 0, 0, 0, 1, 1};
    vecs[5] = '{600, 1000, 0, 0, 0, 0, 512};
    vecs[6] = '{20, 7, 1, 1, 0, 0, 7};

    start = 1'b0; cfg_total = '0; cfg_burst = '0; m_ready = 1'b0;
    fifo_M_Ready = 1'b0; fifo_dout = '0; fifo_empty = 1'b1;
    clr_mon();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_count", longint'(fifo_M_count), 0);
    chk("rst_rd_en", longint'(fifo_rd_en), 0);
    chk("rst_m_valid", longint'(m_valid), 0);
    chk("rst_burst_end", longint'(m_burst_end), 0);
    chk("rst_last", longint'(m_last), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chkw("rst_m_data", m_data, '0);
    rst = 1'b0;
    repeat (2) cyc();

    run_frame(vecs[0]);
    run_frame(vecs[1]);

    // Zero-length frame
    clr_mon();
    cur_blen = 1;
    cfg_total = 20'd0; cfg_burst = 11'd4; start = 1'b1; m_ready = 1'b1;
    cyc();
    s = cyc_n;
    start = 1'b0;
    repeat (8) cyc();
    chk("zero_done_cycle", done_cyc - s, 3);
    chk("zero_done_count", done_cnt, 1);
    chk("zero_pops", pop_idx, 0);
    chk("zero_valid", n_valid, 0);
    chk("zero_busy_end", longint'(busy_s), 0);

    for (int i = 2; i < 7; i++) run_frame(vecs[i]);

    // Reset in the middle of a stalled burst with two words buffered
    clr_mon();
    fq.delete();
    for (int i = 0; i < 32; i++) begin fq.push_back(wval(wr_seq)); wr_seq++; end
    cur_blen = 32;
    cfg_total = 20'd32; cfg_burst = 11'd32; m_ready = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (9) cyc();
    chk("prerst_pops", pop_idx, 2);
    chk("prerst_valid", longint'(mval_s), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_m_valid", longint'(m_valid), 0);
    chkw("async_m_data", m_data, '0);
    chk("async_rd_en", longint'(fifo_rd_en), 0);
    chk("async_busy", longint'(busy), 0);
    chk("async_done", longint'(done), 0);
    chk("async_m_count", longint'(fifo_M_count), 0);
    chk("async_burst_end", longint'(m_burst_end), 0);
    chk("async_last", longint'(m_last), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fq.delete(); fifo_dout = '0; fifo_M_Ready = 1'b0; m_ready = 1'b1;
    clr_mon();
    repeat (4) cyc();
    chk("postrst_no_done", done_cnt, 0);
    chk("postrst_no_pop", pop_idx, 0);
    chk("postrst_idle", longint'(busy_s), 0);
    run_frame(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/upsampling_fifo_reader.md
# upsampling_fifo_reader

Read-side burst controller for the upsampling write FIFO. It drives the FIFO's `M_count` threshold and waits for `M_Ready`. It then pops exactly one burst of words through `rd_en`, absorbing the FIFO's 1-cycle read latency in a 2-entry output buffer, and presents the words on a valid/ready stream toward the DMA write channel. A frame is a programmed number of words split into bursts. `done` pulses when the last word of the frame is accepted downstream.

## Interface
- `WIDTH`, 128, data word width (matches the FIFO).
- `ADDR_BITS`, 10, FIFO count width minus 1. FIFO depth is 2^(ADDR_BITS-1) = 512.
- `clk`  in  1  single clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  pulse; latches `cfg_total` and `cfg_burst` and begins a frame. Ignored while `busy`.
- `cfg_total`  in  20  words in the frame.
- `cfg_burst`  in  ADDR_BITS+1  words per burst.
- `fifo_M_Ready`  in  1  FIFO registered flag, high when data_count >= `fifo_M_count`.
- `fifo_M_count`  out  ADDR_BITS+1  threshold for the current burst.
- `fifo_rd_en`  out  1  FIFO pop.
- `fifo_dout`  in  WIDTH  FIFO data, valid 1 cycle after `fifo_rd_en`.
- `fifo_empty`  in  1  FIFO empty.
- `m_data`  out  WIDTH  output word.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `m_burst_end`  out  1  qualifies the last word of a burst.
- `m_last`  out  1  qualifies the last word of the frame.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle after `done`.
- `done`  out  1  1-cycle pulse.

## Operation
- **States:**
  - `IDLE`
    - `start` -> `LOAD`.
  - `LOAD`
    - burst_len = min(cfg_burst', remaining), where cfg_burst' is `cfg_burst` clamped to [1, 512].
    - `fifo_M_count` <= burst_len.
    - Settle counter <= 2.
    - -> `WAIT_RDY`.
    - If remaining == 0, -> `FLUSH`.
  - `WAIT_RDY`
    - Decrement the settle counter. `fifo_M_Ready` is ignored while settle != 0, because the flag is registered against the previous `M_count`.
    - settle == 0 and `fifo_M_Ready` -> `BURST`.
  - `BURST`
    - Issue pops until burst_len pops have been issued.
    - Then -> `LOAD` if remaining > 0, else -> `FLUSH`.
  - `FLUSH`
    - Wait until the buffer is empty and no pop is in flight.
    - -> `DONE`.
  - `DONE`
    - `done` = 1, -> `IDLE`.
- **Pop rule:**
  - `fifo_rd_en` = (state == `BURST`) & issued_in_burst < burst_len & !`fifo_empty` & (occ + inflight - pop_out) < 2.
  - occ is buffer occupancy, inflight is the previous cycle's `fifo_rd_en`, and pop_out = `m_valid` & `m_ready`.
  - This rule sustains 1 word/cycle when `m_ready` is held high.
- **Tagging:** each pop carries a burst_end bit (last pop of the burst) and a last bit (last pop of the frame). The tags are stored with the data in the buffer.
- **Counters:**
  - remaining (20 b) is decremented per pop.
  - issued_in_burst (ADDR_BITS+1 b) is cleared in `LOAD`.
  - No counter wraps. remaining never underflows, because burst_len <= remaining.
- **Buffer:** 2-entry FIFO with registered outputs; `m_data` is the head entry.
  - Simultaneous write and pop is allowed at any occupancy, including occ == 2 with pop_out.
- **Zero frame:** `cfg_total` == 0 gives `start` -> `LOAD` -> `FLUSH` -> `DONE`, with no pops and `m_valid` never high.
- **start during busy:** ignored, and the config is not re-latched.
- **Reset:** `rst` asynchronously clears all state mid-operation.
  - Buffered words and in-flight words are discarded.
  - No `done` is generated.

## Timing
- **Reset values:**
  - `fifo_M_count` = 0.
  - `fifo_rd_en`, `m_valid`, `m_burst_end`, `m_last`, `busy`, `done` = 0.
  - `m_data` = 0.
  - State = `IDLE`.
- **Start:** `start` at cycle 0 gives `LOAD` at 1, with `fifo_M_count` valid from cycle 2.
  - `WAIT_RDY` runs cycles 2-3, with settle counting down.
  - The earliest `M_Ready` sample is cycle 4, giving `BURST` at 5.
- **Read latency:** `fifo_rd_en` at cycle t gives `fifo_dout` sampled at the end of t+1, and `m_valid` at t+2.
- **Backpressure:** `m_data`, `m_burst_end` and `m_last` are stable while `m_valid` & !`m_ready`.
- **Burst gap:** the `BURST` -> `LOAD` -> `WAIT_RDY` path imposes ≥4 cycles without pops between bursts. The buffer keeps draining during the gap.
- **Done:** `done` fires 2 cycles after the handshake of the `m_last` word (`FLUSH` -> `DONE`). `busy` falls the cycle after `done`.

## Test plan
- **Single burst:** `cfg_total`=8, `cfg_burst`=16, FIFO preloaded with 8 words, `m_ready`=1.
  - `fifo_M_count`=8.
  - 8 consecutive pops and 8 consecutive `m_valid` beats, in order.
  - `m_burst_end`=`m_last`=1 on word 8 only.
  - `done` 2 cycles later.
- **Multi-burst:** `cfg_total`=40, `cfg_burst`=16.
  - `fifo_M_count` sequence is 16, 16, 8.
  - `m_burst_end` on words 16, 32, 40; `m_last` on 40 only.
  - No pops while `M_Ready`=0.
- **Backpressure:** toggle `m_ready` 1-0-0-1 randomly during a 64-word burst.
  - Never more than 2 words buffered plus 1 in flight.
  - No loss or duplication.
  - `m_data` stable while stalled.
- **Gating:** `fifo_empty` asserted mid-burst → `fifo_rd_en`=0 during those cycles. The burst resumes and completes with the exact count.
- **Corner cases:**
  - `cfg_total`=0 → `done` at cycle 3 after `start`, zero pops.
  - `cfg_burst`=0 → bursts of 1.
  - `cfg_burst`=1000 → clamped to 512.
- **Mid-burst reset:** `rst` asserted mid-burst with 2 words buffered.
  - All outputs clear immediately, asynchronously.
  - A new `start` after reset runs a full frame correctly.
